// File: rtl/shader_pkg.sv
// Opcode definitions shared by the issue queue and the shader core.
package shader_pkg;

   typedef enum logic [1:0] {
      OPC_ADD = 2'd0,
      OPC_SUB = 2'd1,
      OPC_MUL = 2'd2,
      OPC_MAC = 2'd3
   } opc_e;

   // Callers zero-extend their opcode field to 32 bits.
   function automatic logic is_legal_opcode(input logic [31:0] op);
      return op <= 32'(OPC_MAC);
   endfunction

endpackage

// File: rtl/shader_issue_queue_if.sv
// Upstream packet channel plus the instruction/data issue channels.
interface shader_issue_queue_if #(
   parameter int WIDTH    = 32,
   parameter int LANES    = 4,
   parameter int OPCODE_W = 4
);
   localparam int VEC_W = WIDTH * LANES;

   logic                in_valid;
   logic                in_ready;
   logic [OPCODE_W-1:0] in_opcode;
   logic                in_is_vector;
   logic [WIDTH-1:0]    in_a_s, in_b_s, in_c_s;
   logic [VEC_W-1:0]    in_a_v, in_b_v, in_c_v;

   logic                instr_valid;
   logic                instr_ready;
   logic [OPCODE_W-1:0] instr_opcode;
   logic                instr_is_vector;

   logic                data_valid;
   logic                data_ready;
   logic [WIDTH-1:0]    data_a_s, data_b_s, data_c_s;
   logic [VEC_W-1:0]    data_a_v, data_b_v, data_c_v;

   modport master (
      output in_valid, in_opcode, in_is_vector, in_a_s, in_b_s, in_c_s,
             in_a_v, in_b_v, in_c_v, instr_ready, data_ready,
      input  in_ready, instr_valid, instr_opcode, instr_is_vector,
             data_valid, data_a_s, data_b_s, data_c_s, data_a_v, data_b_v, data_c_v
   );

   modport slave (
      input  in_valid, in_opcode, in_is_vector, in_a_s, in_b_s, in_c_s,
             in_a_v, in_b_v, in_c_v, instr_ready, data_ready,
      output in_ready, instr_valid, instr_opcode, instr_is_vector,
             data_valid, data_a_s, data_b_s, data_c_s, data_a_v, data_b_v, data_c_v
   );

endinterface

// File: rtl/shader_issue_queue_fifo.sv
// Generic DEPTH x W registered FIFO; flush clears pointers and count, storage is not reset.
module shader_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           wdata,
   output logic [W-1:0]           rdata,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     mem_d [DEPTH];
   logic             do_push, do_pop;

   always_comb begin
      do_push  = push && !flush && (count_q != CNT_W'(DEPTH));
      do_pop   = pop && !flush && (count_q != '0);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) mem_q <= mem_d;

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/shader_issue_queue.sv
// Issue queue: drops illegal opcodes, buffers legal packets, issues head on both channels at once.
module shader_issue_queue
   import shader_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int LANES    = 4,
   parameter int OPCODE_W = 4,
   parameter int DEPTH    = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   shader_issue_queue_if.slave    bus,
   output logic [$clog2(DEPTH):0] count,
   output logic                   err_illegal,
   output logic [7:0]             drop_cnt
);
   localparam int VEC_W = WIDTH * LANES;
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int PAY_W = OPCODE_W + 1 + 3 * WIDTH + 3 * VEC_W;

   logic             init_q, init_d;
   logic             err_q, err_d;
   logic [7:0]       drop_q, drop_d;
   logic             legal, accept, push, pop, full;
   logic [PAY_W-1:0] wdata, rdata;

   assign full  = (count == CNT_W'(DEPTH));
   assign legal = is_legal_opcode(32'(bus.in_opcode));

   // init_q keeps in_ready low through reset and releases it on the first edge after.
   assign bus.in_ready = init_q && !full && !flush;
   assign accept       = bus.in_valid && bus.in_ready;
   assign push         = accept && legal;
   assign pop          = (count != '0) && bus.instr_ready && bus.data_ready;

   assign bus.instr_valid = (count != '0);
   assign bus.data_valid  = (count != '0);

   assign wdata = {bus.in_opcode, bus.in_is_vector, bus.in_a_s, bus.in_b_s, bus.in_c_s,
                   bus.in_a_v, bus.in_b_v, bus.in_c_v};
   assign {bus.instr_opcode, bus.instr_is_vector, bus.data_a_s, bus.data_b_s, bus.data_c_s,
           bus.data_a_v, bus.data_b_v, bus.data_c_v} = rdata;

   always_comb begin
      init_d = 1'b1;
      err_d  = err_q;
      drop_d = drop_q;
      if (accept && !legal) begin
         err_d = 1'b1;
         if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_q <= 1'b0;
         err_q  <= 1'b0;
         drop_q <= '0;
      end else begin
         init_q <= init_d;
         err_q  <= err_d;
         drop_q <= drop_d;
      end
   end

   assign err_illegal = err_q;
   assign drop_cnt    = drop_q;

   shader_fifo #(
      .DEPTH (DEPTH),
      .W     (PAY_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .push  (push),
      .pop   (pop),
      .wdata (wdata),
      .rdata (rdata),
      .count (count)
   );

endmodule
